// File: rtl/macc_sched_pkg.sv
// Shared state encoding, default widths and element-array type for the MACC window scheduler.
package macc_sched_pkg;

   localparam int unsigned DEF_N               = 32;
   localparam int unsigned DEF_CNT_W           = 16;
   localparam int unsigned DEF_ARRAY_WIDTH     = 3;
   localparam int unsigned DEF_NUM_TOT_ELEMENT = DEF_ARRAY_WIDTH * DEF_ARRAY_WIDTH;

   typedef enum logic [1:0] {
      StIdle,
      StKernel,
      StStream,
      StDrain
   } sched_state_e;

   // Window / kernel as an indexable array of elements; element 0 sits in the low bits.
   typedef logic [DEF_NUM_TOT_ELEMENT-1:0][DEF_N-1:0] elem_array_t;

endpackage

// File: rtl/macc_pipe_reg.sv
// Valid/ready register slice: accepts new data whenever it is empty or being drained this cycle.
module macc_pipe_reg #(
   parameter int unsigned W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   logic         valid_q;
   logic [W-1:0] data_q;

   assign in_ready  = !valid_q || out_ready;
   assign out_valid = valid_q;
   assign out_data  = data_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else if (in_ready) begin
         valid_q <= in_valid;
         if (in_valid) begin
            data_q <= in_data;
         end
      end
   end

endmodule

// File: rtl/macc_window_scheduler.sv
// Job/kernel/window sequencer around an external combinational MACC with a 2-stage pipeline.
// Optional kernel reuse across jobs is enabled by defining MACC_SCHED_KERNEL_REUSE_EN.
module macc_window_scheduler
   import macc_sched_pkg::*;
#(
   parameter int unsigned Q               = 15,
   parameter int unsigned N               = DEF_N,
   parameter int unsigned ARRAY_WIDTH     = DEF_ARRAY_WIDTH,
   parameter int unsigned NUM_TOT_ELEMENT = ARRAY_WIDTH * ARRAY_WIDTH,
   parameter int unsigned CNT_W           = DEF_CNT_W
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         job_valid,
   output logic                         job_ready,
   input  logic [CNT_W-1:0]             job_count,
   input  logic [N-1:0]                 job_bias,
   input  logic                         job_reuse,
   input  logic                         kern_valid,
   output logic                         kern_ready,
   input  logic [NUM_TOT_ELEMENT*N-1:0] kern_data,
   input  logic                         win_valid,
   output logic                         win_ready,
   input  logic [NUM_TOT_ELEMENT*N-1:0] win_data,
   output logic [NUM_TOT_ELEMENT*N-1:0] macc_array_1,
   output logic [NUM_TOT_ELEMENT*N-1:0] macc_array_2,
   output logic [N-1:0]                 macc_bias,
   input  logic [N-1:0]                 macc_result,
   output logic                         res_valid,
   input  logic                         res_ready,
   output logic [N-1:0]                 res_data,
   output logic                         res_last,
   output logic                         busy,
   output logic                         done
);

   // Q only matters to the MACC itself.
   localparam int unsigned unused_q = Q;
   localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

   sched_state_e                 state_q, state_d;
   logic [CNT_W-1:0]             cnt_total_q, issue_cnt_q, issue_nxt;
   logic                         kernel_loaded_q;
   logic                         s1_valid_q, s1_last_q;
   logic                         done_q;
   logic [NUM_TOT_ELEMENT*N-1:0] macc_array_1_q, macc_array_2_q;
   logic [N-1:0]                 macc_bias_q;

   logic job_fire, kern_fire, win_fire, res_fire_last;
   logic adv2, issue_last, kernel_skip;
   logic [N:0] s2_data;

   assign job_fire      = job_valid && job_ready;
   assign kern_fire     = kern_valid && kern_ready;
   assign win_fire      = win_valid && win_ready;
   assign res_fire_last = res_valid && res_ready && res_last;
   assign issue_nxt     = issue_cnt_q + CntOne;
   assign issue_last    = (issue_nxt == cnt_total_q);

`ifdef MACC_SCHED_KERNEL_REUSE_EN
   assign kernel_skip = job_reuse && kernel_loaded_q;
`else
   logic unused_reuse;
   assign kernel_skip  = 1'b0;
   assign unused_reuse = job_reuse ^ kernel_loaded_q;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (job_fire && (job_count != '0)) begin
               state_d = kernel_skip ? StStream : StKernel;
            end
         end
         StKernel: begin
            if (kern_fire) state_d = StStream;
         end
         StStream: begin
            if (win_fire && issue_last) state_d = StDrain;
         end
         StDrain: begin
            if (res_fire_last) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      job_ready  = 1'b0;
      kern_ready = 1'b0;
      win_ready  = 1'b0;
      busy       = (state_q != StIdle);
      unique case (state_q)
         StIdle:   job_ready  = !done_q;
         StKernel: kern_ready = 1'b1;
         // A new window may enter stage 1 only if the current occupant moves on this cycle.
         StStream: win_ready  = (issue_cnt_q < cnt_total_q) && (!s1_valid_q || adv2);
         default:  ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_total_q     <= '0;
         issue_cnt_q     <= '0;
         kernel_loaded_q <= 1'b0;
         s1_valid_q      <= 1'b0;
         s1_last_q       <= 1'b0;
         done_q          <= 1'b0;
         macc_array_1_q  <= '0;
         macc_array_2_q  <= '0;
         macc_bias_q     <= '0;
      end else begin
         done_q <= 1'b0;
         if (job_fire) begin
            cnt_total_q <= job_count;
            macc_bias_q <= job_bias;
            issue_cnt_q <= '0;
            if (job_count == '0) done_q <= 1'b1;
         end
         if (kern_fire) begin
            macc_array_2_q  <= kern_data;
            kernel_loaded_q <= 1'b1;
         end
         if (win_fire) begin
            macc_array_1_q <= win_data;
            issue_cnt_q    <= issue_nxt;
            s1_last_q      <= issue_last;
            s1_valid_q     <= 1'b1;
         end else if (adv2) begin
            s1_valid_q <= 1'b0;
         end
         if ((state_q == StDrain) && res_fire_last) done_q <= 1'b1;
      end
   end

   macc_pipe_reg #(
      .W (N + 1)
   ) u_stage2 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (s1_valid_q),
      .in_ready  (adv2),
      .in_data   ({s1_last_q, macc_result}),
      .out_valid (res_valid),
      .out_ready (res_ready),
      .out_data  (s2_data)
   );

   assign {res_last, res_data} = s2_data;
   assign macc_array_1         = macc_array_1_q;
   assign macc_array_2         = macc_array_2_q;
   assign macc_bias            = macc_bias_q;
   assign done                 = done_q;

endmodule

// File: tb/tb_macc_window_scheduler.sv
// Bench for macc_window_scheduler: table-driven jobs, hand-written corner sequences, and
// randomized jobs scored against a queue-based model with a sign-magnitude Q15 MACC.
module tb_macc_window_scheduler;
   import macc_sched_pkg::*;

   localparam int unsigned N     = 32;
   localparam int unsigned CNT_W = 16;
   localparam int unsigned NE    = 9;
   localparam int unsigned DW    = NE * N;
`ifdef MACC_SCHED_KERNEL_REUSE_EN
   localparam bit ReuseEn = 1'b1;
`else
   localparam bit ReuseEn = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   logic job_valid, job_ready, job_reuse;
   logic [CNT_W-1:0] job_count;
   logic [N-1:0] job_bias;
   logic kern_valid, kern_ready, win_valid, win_ready;
   logic [DW-1:0] kern_data, win_data, macc_array_1, macc_array_2;
   logic [N-1:0] macc_bias, macc_result, res_data;
   logic res_valid, res_ready, res_last, busy, done;
   logic rr_mode, rr_val, rr_rand;

   always #5 clk = ~clk;

   // External MACC: sign-magnitude Q15 dot product plus bias, ReLU at the output.
   function automatic logic [N-1:0] macc_fn(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                            input logic [N-1:0] bias);
      longint acc, p;
      acc = longint'(bias[30:0]);
      if (bias[31]) acc = -acc;
      for (int i = 0; i < NE; i++) begin
         p = (longint'(a[i*N +: 31]) * longint'(b[i*N +: 31])) >>> 15;
         if (a[i*N+31] ^ b[i*N+31]) acc -= p;
         else acc += p;
      end
      if (acc <= 0) return '0;
      return {1'b0, acc[30:0]};
   endfunction

   function automatic elem_array_t fill(input logic [N-1:0] v);
      elem_array_t r;
      for (int i = 0; i < NE; i++) r[i] = v;
      return r;
   endfunction

   function automatic logic [N-1:0] rand_sm();
      return {($urandom_range(0, 1) == 1), 13'b0, 18'($urandom_range(0, 32'h3FFFF))};
   endfunction

   function automatic elem_array_t rand_arr();
      elem_array_t r;
      for (int i = 0; i < NE; i++) r[i] = rand_sm();
      return r;
   endfunction

   assign macc_result = macc_fn(macc_array_1, macc_array_2, macc_bias);
   assign res_ready   = rr_mode ? rr_rand : rr_val;

   macc_window_scheduler u_dut (
      .clk          (clk),
      .rst          (rst),
      .job_valid    (job_valid),
      .job_ready    (job_ready),
      .job_count    (job_count),
      .job_bias     (job_bias),
      .job_reuse    (job_reuse),
      .kern_valid   (kern_valid),
      .kern_ready   (kern_ready),
      .kern_data    (kern_data),
      .win_valid    (win_valid),
      .win_ready    (win_ready),
      .win_data     (win_data),
      .macc_array_1 (macc_array_1),
      .macc_array_2 (macc_array_2),
      .macc_bias    (macc_bias),
      .macc_result  (macc_result),
      .res_valid    (res_valid),
      .res_ready    (res_ready),
      .res_data     (res_data),
      .res_last     (res_last),
      .busy         (busy),
      .done         (done)
   );

   initial begin
      rr_rand = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         rr_rand = ($urandom_range(0, 1) == 1);
      end
   end

   int vectors = 0;
   int miscompares = 0;

   // Reference model state
   logic [DW-1:0] m_kernel = '0;
   logic          m_kloaded = 1'b0;
   logic [N-1:0]  m_bias = '0;
   int            m_cnt = 0, m_idx = 0;
   logic [N:0]    exp_q[$];
   bit            done_due = 0, done_seen = 0;
   int            cyc = 0, first_win_cyc = 0, first_res_cyc = 0, n_res = 0;
   logic [N-1:0]  last_res = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      vectors++;
      miscompares++;
      $display("FAIL %s: got event expected none/other", name);
   endtask

   // Observes the handshakes that will complete at the coming rising edge.
   task automatic monitor();
      logic [N:0] e;
      cyc++;
      if (rst) begin
         exp_q.delete();
         done_due  = 0;
         m_kloaded = 1'b0;
         m_idx     = 0;
         m_cnt     = 0;
         return;
      end
      if (done_due || done) begin
         check("done pulse", done, done_due);
         if (done_due) check("job_ready in done cycle", job_ready, 0);
         if (done) done_seen = 1;
      end
      done_due = 0;
      if (res_valid && res_ready) begin
         if (n_res == 0) first_res_cyc = cyc;
         if (exp_q.size() == 0) begin
            fail("unexpected result");
         end else begin
            e = exp_q.pop_front();
            check("res_data", res_data, e[N-1:0]);
            check("res_last", res_last, e[N]);
            if (e[N]) done_due = 1;
         end
         n_res++;
         last_res = res_data;
      end
      if (win_valid && win_ready) begin
         m_idx++;
         if (m_idx == 1) first_win_cyc = cyc;
         if (m_idx > m_cnt) fail("window beyond job count");
         exp_q.push_back({(m_idx == m_cnt), macc_fn(win_data, m_kernel, m_bias)});
      end
      if (kern_valid && kern_ready) begin
         m_kernel  = kern_data;
         m_kloaded = 1'b1;
      end
      if (job_valid && job_ready) begin
         m_cnt  = int'(job_count);
         m_bias = job_bias;
         m_idx  = 0;
         n_res  = 0;
         if (job_count == '0) done_due = 1;
      end
   endtask

   task automatic tick();
      @(negedge clk);
      monitor();
      @(posedge clk);
      #2;
   endtask

   task automatic send_job(input int cnt, input logic [N-1:0] bias, input logic reuse);
      int n = 0;
      job_valid = 1'b1;
      job_count = cnt[CNT_W-1:0];
      job_bias  = bias;
      job_reuse = reuse;
      while (!job_ready && n < 50) begin tick(); n++; end
      if (!job_ready) fail("job_ready timeout");
      tick();
      job_valid = 1'b0;
   endtask

   task automatic send_kernel(input logic [DW-1:0] d);
      int n = 0;
      kern_valid = 1'b1;
      kern_data  = d;
      while (!kern_ready && n < 50) begin tick(); n++; end
      if (!kern_ready) fail("kern_ready timeout");
      tick();
      kern_valid = 1'b0;
   endtask

   task automatic send_window(input logic [DW-1:0] d);
      int n = 0;
      win_valid = 1'b1;
      win_data  = d;
      while (!win_ready && n < 50) begin tick(); n++; end
      if (!win_ready) fail("win_ready timeout");
      tick();
      win_valid = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while (!done_seen && n < 100) begin tick(); n++; end
      check(name, done_seen, 1);
   endtask

   typedef struct {
      int          cnt;
      logic [31:0] bias;
      logic [31:0] kern;
      logic [31:0] win;
      logic [31:0] exp_res;
   } vec_t;

   vec_t tbl[5];

   initial begin
      int c0, k, cnt;
      logic acc, saw, reuse, need_k;
      elem_array_t w;

      tbl[0] = '{4, 32'h0000_8000, 32'h0000_8000, 32'h0000_8000, 32'h0005_0000};
      tbl[1] = '{3, 32'h0000_0000, 32'h0001_0000, 32'h0000_8000, 32'h0009_0000};
      tbl[2] = '{2, 32'h8000_8000, 32'h0000_8000, 32'h0000_4000, 32'h0001_C000};
      tbl[3] = '{1, 32'h8005_0000, 32'h0000_8000, 32'h0000_8000, 32'h0000_0000};
      tbl[4] = '{5, 32'h0000_8000, 32'h8000_8000, 32'h0000_8000, 32'h0000_0000};

      rst = 1'b1;
      job_valid = 1'b0; job_count = '0; job_bias = '0; job_reuse = 1'b0;
      kern_valid = 1'b0; kern_data = '0; win_valid = 1'b0; win_data = '0;
      rr_mode = 1'b0; rr_val = 1'b1;

      tick(); tick();
      check("reset busy", busy, 0);
      check("reset res_valid", res_valid, 0);
      check("reset done", done, 0);
      check("reset kern_ready", kern_ready, 0);
      check("reset win_ready", win_ready, 0);
      check("reset res_data", res_data, 0);
      check("reset res_last", res_last, 0);
      check("reset macc_bias", macc_bias, 0);
      check("reset macc_array_1", macc_array_1[63:0], 0);
      check("reset macc_array_2", macc_array_2[63:0], 0);
      rst = 1'b0;
      tick();
      check("idle job_ready", job_ready, 1);

      // Table-driven jobs at full throughput
      for (int i = 0; i < 5; i++) begin
         done_seen = 0;
         send_job(tbl[i].cnt, tbl[i].bias, 1'b0);
         send_kernel(fill(tbl[i].kern));
         c0 = cyc;
         for (int j = 0; j < tbl[i].cnt; j++) send_window(fill(tbl[i].win));
         check("window throughput", cyc - c0, tbl[i].cnt);
         wait_done("table done");
         check("latency", first_res_cyc - first_win_cyc, 2);
         check("result count", n_res, tbl[i].cnt);
         check("table result", last_res, tbl[i].exp_res);
      end

      // Backpressure: two windows in flight, then stall
      done_seen = 0;
      send_job(4, 32'h0000_8000, 1'b0);
      send_kernel(fill(32'h0000_8000));
      rr_val = 1'b0;
      k = 0;
      for (int c = 0; c < 10; c++) begin
         win_valid = 1'b1;
         win_data  = fill(32'((k + 1) * 32'h8000));
         acc = win_ready;
         tick();
         if (acc) k++;
      end
      check("accepted under backpressure", k, 2);
      check("win_ready stalled", win_ready, 0);
      check("result held", res_valid, 1);
      rr_val = 1'b1;
      for (int c = 0; c < 50 && k < 4; c++) begin
         win_valid = 1'b1;
         win_data  = fill(32'((k + 1) * 32'h8000));
         acc = win_ready;
         tick();
         if (acc) k++;
      end
      win_valid = 1'b0;
      wait_done("backpressure done");
      check("backpressure result count", n_res, 4);

      // Zero-count job
      done_seen = 0;
      send_job(0, 32'h0000_1234, 1'b0);
      check("zero-count done", done, 1);
      check("zero-count busy", busy, 0);
      check("zero-count job_ready", job_ready, 0);
      saw = 1'b0;
      for (int c = 0; c < 4; c++) begin
         tick();
         saw = saw | kern_ready | win_ready;
      end
      check("zero-count no kern/win ready", saw, 0);
      check("zero-count done seen", done_seen, 1);

      // Negative element: ReLU output, normal handshake
      done_seen = 0;
      send_job(1, 32'h0, 1'b0);
      send_kernel('0);
      w = '0;
      w[0] = 32'h8001_8000;
      send_window(w);
      wait_done("negative done");
      check("negative res_data", last_res, 0);
      check("negative result count", n_res, 1);

      // Reset after 2 of 5 windows
      done_seen = 0;
      send_job(5, 32'h0000_8000, 1'b0);
      send_kernel(fill(32'h0000_8000));
      send_window(fill(32'h0000_8000));
      send_window(fill(32'h0000_8000));
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("post-reset busy", busy, 0);
      check("post-reset res_valid", res_valid, 0);
      check("post-reset done", done, 0);
      check("post-reset job_ready", job_ready, 1);
      for (int c = 0; c < 3; c++) tick();
      check("no done after reset", done_seen, 0);
      // Kernel was dropped by reset, so a reuse request must still load one.
      send_job(2, 32'h0, 1'b1);
      check("reuse without kernel enters KERNEL", kern_ready, 1);
      send_kernel(fill(32'h0000_8000));
      send_window(fill(32'h0001_0000));
      send_window(fill(32'h0001_0000));
      wait_done("post-reset job done");
      check("post-reset result", last_res, 32'h0009_0000);

      // Kernel reuse
      done_seen = 0;
      send_job(2, 32'h0, 1'b0);
      send_kernel(fill(32'h0001_0000));
      send_window(fill(32'h0000_8000));
      send_window(fill(32'h0000_8000));
      wait_done("reuse first job done");
      done_seen = 0;
      send_job(2, 32'h0000_8000, 1'b1);
      check("reuse kern_ready", kern_ready, !ReuseEn);
      if (!ReuseEn) send_kernel(fill(32'h0001_8000));
      send_window(fill(32'h0000_8000));
      send_window(fill(32'h0000_8000));
      wait_done("reuse second job done");
      check("reuse result", last_res, ReuseEn ? 32'h0009_8000 : 32'h000E_0000);

      // Randomized jobs with random backpressure and window gaps
      rr_mode = 1'b1;
      for (int j = 0; j < 25; j++) begin
         cnt    = int'($urandom_range(0, 6));
         reuse  = ($urandom_range(0, 1) == 1);
         need_k = (cnt != 0) && !(ReuseEn && reuse && m_kloaded);
         done_seen = 0;
         send_job(cnt, rand_sm(), reuse);
         if (cnt != 0) check("random kern_ready", kern_ready, need_k);
         if (need_k) send_kernel(rand_arr());
         for (int i = 0; i < cnt; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            send_window(rand_arr());
         end
         wait_done("random done");
         check("random result count", n_res, cnt);
      end
      rr_mode = 1'b0;
      for (int c = 0; c < 3; c++) tick();
      check("final idle", busy, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/macc_window_scheduler.md
Name: macc_window_scheduler

Overview:
- Sequences one MACC convolution unit (9-element fixed-point dot product plus bias, combinational, ReLU at output) across a stream of input windows for one job.
- Per job: accept a descriptor (window count, bias), load one kernel, stream windows through a registered 2-stage pipeline around the MACC, and emit results with backpressure.
- Sits between the window fetch logic and the feature-map writeback. The MACC instance is external and connected through the macc_* ports.

Parameters:
- Q, 15, fractional bits (passed through to the MACC; informational here).
- N, 32, data word width.
- ARRAY_WIDTH, 3, kernel side length.
- NUM_TOT_ELEMENT, ARRAY_WIDTH*ARRAY_WIDTH, elements per window and per kernel.
- CNT_W, 16, width of the window counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- job_valid  in  1  job descriptor valid
- job_ready  out  1  scheduler accepts a descriptor (IDLE only)
- job_count  in  CNT_W  number of windows in the job
- job_bias  in  N  bias for the job
- job_reuse  in  1  reuse the previously loaded kernel (see Optional Feature)
- kern_valid / kern_ready  in / out  1  kernel handshake
- kern_data  in  NUM_TOT_ELEMENT*N  kernel elements
- win_valid / win_ready  in / out  1  window handshake
- win_data  in  NUM_TOT_ELEMENT*N  window elements
- macc_array_1  out  NUM_TOT_ELEMENT*N  registered window to the MACC
- macc_array_2  out  NUM_TOT_ELEMENT*N  registered kernel to the MACC
- macc_bias  out  N  registered job bias
- macc_result  in  N  combinational MACC output
- res_valid / res_ready  out / in  1  result handshake
- res_data  out  N  registered result
- res_last  out  1  marks the final result of the job
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at job completion

Behaviour:
- Handshakes: transfer occurs when valid && ready. Valid, once asserted, holds with stable data until the transfer.
- Reset: state=IDLE; all valids, res_data, res_last, done, counters, kernel_loaded cleared; macc_* registers cleared to 0.
- Reset mid-operation: the pipeline is flushed, in-flight results are lost, and no done pulse is produced.
- FSM states: IDLE, KERNEL, STREAM, DRAIN.
  - IDLE: job_ready=1. On a job transfer, latch job_count into cnt_total and job_bias into macc_bias, and clear issue_cnt.
    - If job_count==0: done pulses the next cycle, state stays IDLE, and no kernel is consumed.
    - Otherwise go to KERNEL.
  - KERNEL: kern_ready=1. On transfer, latch kern_data into macc_array_2, set kernel_loaded, and go to STREAM.
  - STREAM: win_ready = (issue_cnt < cnt_total) && (!s1_valid || adv2).
    - On a window transfer: macc_array_1 <= win_data, s1_valid <= 1, issue_cnt++.
    - When issue_cnt reaches cnt_total, go to DRAIN.
  - DRAIN: wait for the result with res_last to transfer. Then done=1 for one cycle and state returns to IDLE; job_ready is not asserted in the done cycle.
- Pipeline:
  - Stage 1 is the macc_array_1 register with s1_valid.
  - Stage 2 is res_data/res_valid.
  - adv2 = !res_valid || res_ready.
  - When adv2 && s1_valid: res_data <= macc_result, res_valid <= 1, res_last <= (stage-1 entry was window cnt_total), s1_valid <= win transfer this cycle.
  - When adv2 && !s1_valid: res_valid <= 0.
- Latency: window accepted in cycle T produces res_valid in cycle T+2 with no backpressure.
- Throughput: 1 result per cycle. Full throughput is sustained with res_ready held high.
- Backpressure: with res_ready low, at most 2 windows are in flight, then win_ready drops.
- No arithmetic is done in this block. Counters are unsigned CNT_W bits, and issue_cnt never wraps because it is bounded by cnt_total ≤ 2^CNT_W−1.

Optional Feature:
- Macro: MACC_SCHED_KERNEL_REUSE_EN.
- Defined: if job_reuse=1 and kernel_loaded=1 at job acceptance, skip KERNEL and go directly to STREAM, keeping macc_array_2. If job_reuse=1 but kernel_loaded=0, KERNEL is entered normally.
- Undefined: job_reuse is ignored and every nonzero job enters KERNEL.

Decomposition:
- Package macc_sched_pkg holds:
  - the state enum (IDLE, KERNEL, STREAM, DRAIN);
  - default widths N, CNT_W, NUM_TOT_ELEMENT;
  - a packed window/kernel type (array [NUM_TOT_ELEMENT] of logic [N-1:0]).
- One sub-module is natural: macc_pipe_reg, a parameterised valid/ready register slice, used for stage 2.
- The FSM and stage 1 stay in the top module.

Test Plan:
- Basic job:
  - Stimulus: job_count=4, bias=0x00008000 (1.0); kernel all 0x00008000; windows all 0x00008000; res_ready=1.
  - Response: 4 results of 0x00050000 (9.0+1.0) at T+2 after each window, res_last on the 4th, done the cycle after its transfer.
- Backpressure:
  - Stimulus: same job with res_ready=0 for 10 cycles.
  - Response: win_ready drops after 2 windows are accepted; no result lost or duplicated; the order matches the input order after release.
- Zero-count job:
  - Stimulus: job_count=0.
  - Response: done pulses 1 cycle after job acceptance; kern_ready and win_ready stay 0.
- Negative sum:
  - Stimulus: window element 0 = 0x80018000 (−3.0 in Q15 sign-magnitude), remaining elements and kernel 0, bias 0.
  - Response: res_data=0 from the MACC ReLU, and the handshake completes normally.
- Reset mid-stream:
  - Stimulus: assert rst for 1 cycle after 2 of 5 windows are accepted.
  - Response: next cycle state=IDLE, res_valid=0, busy=0, no done pulse; a new job runs correctly afterwards.
- Kernel reuse (macro defined):
  - Stimulus: second job with job_reuse=1.
  - Response: kern_ready never asserts and results use the first job's kernel.
  - Macro undefined: kern_ready asserts for the second job.
